pipe_catcher: RTL and testbench



---
 rtl/pipe_catcher_if.sv | 28 ++
 rtl/pipe_catcher.sv | 101 ++++++++++
 tb/tb_pipe_catcher.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_catcher_if.sv
// Handshake bundle between a fixed-latency pipeline, its launcher, the catcher and the downstream consumer.
// Latency: none (wires only).
// Backpressure: out_ready from the consumer; issue_ready grants launches; ret_* cannot be stalled.
// Ports: issue_ready/issue_valid (launch credit), ret_valid/ret_data (returning result),
//        out_valid/out_data/out_ready (buffered result towards the consumer).
interface pipe_catcher_if #(
  parameter int WIDTH = 8
);
  logic             issue_ready;
  logic             issue_valid;
  logic             ret_valid;
  logic [WIDTH-1:0] ret_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // Environment side: launcher, fixed-latency unit and consumer.
  modport master (
    input  issue_ready, out_valid, out_data,
    output issue_valid, ret_valid, ret_data, out_ready
  );

  // Catcher side.
  modport slave (
    output issue_ready, out_valid, out_data,
    input  issue_valid, ret_valid, ret_data, out_ready
  );
endinterface

// File: rtl/pipe_catcher.sv
// Credit-gated catcher: reserves a FIFO slot per launch and buffers fixed-latency results for a stallable consumer.
// Latency: ret -> out 1 cycle; 0 cycles when PIPE_CATCHER_BYPASS_EN is defined and the FIFO is empty.
// Backpressure: out_ready stalls the FIFO head; upstream is throttled by issue_ready (credits); ret is never stalled.
// Ports: clk, rst_n (synchronous, active-low); bus (pipe_catcher_if.slave);
//        credits/count (free credits, held entries); err (sticky protocol violation).
// Optional macro: PIPE_CATCHER_BYPASS_EN enables the combinational ret -> out path when empty.
module pipe_catcher #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_catcher_if.slave bus,
  output logic [CW-1:0] credits,
  output logic [CW-1:0] count,
  output logic          err
);

  // Elaboration-time sanity checks on the configuration.
  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_catcher: DEPTH must be >= 1");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("pipe_catcher: LATENCY must be >= 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;

  logic empty, full;
  logic launch, bad_issue, pop, rd, wr, overflow, byp_take, cr_over;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign bus.issue_ready = (credits != '0);
  assign launch          = bus.issue_valid & bus.issue_ready;
  assign bad_issue       = bus.issue_valid & ~bus.issue_ready;

`ifdef PIPE_CATCHER_BYPASS_EN
  // An empty FIFO forwards the arriving word straight through; if the
  // consumer takes it this cycle it is never written.
  assign bus.out_valid = ~empty | bus.ret_valid;
  assign bus.out_data  = empty ? bus.ret_data : mem[rptr];
  assign byp_take      = empty & bus.ret_valid & bus.out_ready;
`else
  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem[rptr];
  assign byp_take      = 1'b0;
`endif

  assign pop      = bus.out_valid & bus.out_ready;
  assign rd       = pop & ~empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign overflow = bus.ret_valid & full & ~pop;
  assign wr       = bus.ret_valid & ~byp_take & ~overflow;
  // A pop with no matching outstanding credit indicates an unannounced result.
  assign cr_over  = pop & ~launch & (credits == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits <= CW'(DEPTH);
      count   <= '0;
      rptr    <= '0;
      wptr    <= '0;
      err     <= 1'b0;
    end else begin
      if (launch & ~pop) begin
        credits <= credits - CW'(1);
      end else if (pop & ~launch & ~cr_over) begin
        credits <= credits + CW'(1);
      end

      if (wr & ~rd) begin
        count <= count + CW'(1);
      end else if (rd & ~wr) begin
        count <= count - CW'(1);
      end

      if (wr) wptr <= ptr_next(wptr);
      if (rd) rptr <= ptr_next(rptr);

      if (bad_issue | overflow | cr_over) err <= 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed through count.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= bus.ret_data;
  end

endmodule

// File: tb/tb_pipe_catcher.sv
// Self-checking bench for pipe_catcher (DEPTH=4, LATENCY=3, WIDTH=8).
// Latency: models a 3-cycle fixed-latency unit between launch and ret_valid.
// Backpressure: consumer ready is driven from tables, sequences and random draws.
module tb_pipe_catcher;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;
`ifdef PIPE_CATCHER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] credits;
  logic [2:0] count;
  logic       err;

  pipe_catcher_if #(.WIDTH(WIDTH)) bus ();

  pipe_catcher #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .credits(credits),
    .count  (count),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a queue of held words, a credit counter and a sticky error bit.
  logic [7:0] mq[$];
  int         m_cr;
  bit         m_err;
  // Environment: the fixed-latency unit as a LAT-deep delay line.
  bit         lat_v[LAT];
  logic [7:0] lat_d[LAT];
  bit         last_ov;
  logic [7:0] last_od;

  task automatic do_reset();
    rst_n = 1'b0;
    bus.issue_valid = 1'b0;
    bus.ret_valid   = 1'b0;
    bus.ret_data    = '0;
    bus.out_ready   = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      lat_v[i] = 1'b0;
      lat_d[i] = '0;
    end
    mq.delete();
    m_cr  = DEPTH;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One cycle: drive inputs, compare against the model at the falling edge,
  // then advance the model and the delay line across the rising edge.
  task automatic step(input bit iv, input bit ordy, input logic [7:0] ldat);
    bit         rv, e_rdy, e_ov, launch, pop, took;
    logic [7:0] rd, e_od;
    rv = lat_v[LAT-1];
    rd = lat_d[LAT-1];
    bus.issue_valid = iv;
    bus.ret_valid   = rv;
    bus.ret_data    = rd;
    bus.out_ready   = ordy;
    e_rdy = (m_cr != 0);
    e_ov  = (mq.size() != 0) || (BYP && rv);
    e_od  = (mq.size() != 0) ? mq[0] : rd;
    @(negedge clk);
    chk("issue_ready", int'(bus.issue_ready), int'(e_rdy));
    chk("out_valid", int'(bus.out_valid), int'(e_ov));
    if (e_ov) chk("out_data", int'(bus.out_data), int'(e_od));
    chk("credits", int'(credits), m_cr);
    chk("count", int'(count), mq.size());
    chk("err", int'(err), int'(m_err));
    last_ov = bus.out_valid;
    last_od = bus.out_data;

    launch = iv && e_rdy;
    pop    = e_ov && ordy;
    took   = 1'b0;
    if (iv && !e_rdy) m_err = 1'b1;
    if (pop) begin
      if (mq.size() != 0) void'(mq.pop_front());
      else took = 1'b1;
    end
    if (rv && !took) begin
      if (mq.size() >= DEPTH) m_err = 1'b1;
      else mq.push_back(rd);
    end
    if (launch && !pop) m_cr--;
    else if (pop && !launch) begin
      if (m_cr == DEPTH) m_err = 1'b1;
      else m_cr++;
    end

    for (int i = LAT - 1; i > 0; i--) begin
      lat_v[i] = lat_v[i-1];
      lat_d[i] = lat_d[i-1];
    end
    lat_v[0] = launch;
    lat_d[0] = ldat;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         iv;
    bit         rv;
    logic [7:0] rd;
    bit         ordy;
    bit         e_rdy;
    bit         e_ov;
    logic [7:0] e_od;
    int         e_cr;
    int         e_cnt;
    bit         e_err;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int delivered, drops, thr;

    // Fill four launches, return 11..44 three cycles later with the consumer stalled,
    // then violate both ways (issue without credit, push into a full FIFO), then drain.
    tbl[0]  = '{0, 0, 8'h00, 0, 1, 0,   8'h00, 4, 0, 0};
    tbl[1]  = '{1, 0, 8'h00, 0, 1, 0,   8'h00, 4, 0, 0};
    tbl[2]  = '{1, 0, 8'h00, 0, 1, 0,   8'h00, 3, 0, 0};
    tbl[3]  = '{1, 0, 8'h00, 0, 1, 0,   8'h00, 2, 0, 0};
    tbl[4]  = '{1, 1, 8'h11, 0, 1, BYP, 8'h11, 1, 0, 0};
    tbl[5]  = '{0, 1, 8'h22, 0, 0, 1,   8'h11, 0, 1, 0};
    tbl[6]  = '{0, 1, 8'h33, 0, 0, 1,   8'h11, 0, 2, 0};
    tbl[7]  = '{0, 1, 8'h44, 0, 0, 1,   8'h11, 0, 3, 0};
    tbl[8]  = '{0, 0, 8'h00, 0, 0, 1,   8'h11, 0, 4, 0};
    tbl[9]  = '{1, 0, 8'h00, 0, 0, 1,   8'h11, 0, 4, 0};
    tbl[10] = '{0, 1, 8'h55, 0, 0, 1,   8'h11, 0, 4, 1};
    tbl[11] = '{0, 0, 8'h00, 1, 0, 1,   8'h11, 0, 4, 1};
    tbl[12] = '{0, 0, 8'h00, 1, 1, 1,   8'h22, 1, 3, 1};
    tbl[13] = '{0, 0, 8'h00, 1, 1, 1,   8'h33, 2, 2, 1};
    tbl[14] = '{0, 0, 8'h00, 1, 1, 1,   8'h44, 3, 1, 1};
    tbl[15] = '{0, 0, 8'h00, 0, 1, 0,   8'h00, 4, 0, 1};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.issue_valid = tbl[i].iv;
      bus.ret_valid   = tbl[i].rv;
      bus.ret_data    = tbl[i].rd;
      bus.out_ready   = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_issue_ready", i), int'(bus.issue_ready), int'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_out_valid", i), int'(bus.out_valid), int'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), int'(bus.out_data), int'(tbl[i].e_od));
      chk($sformatf("tbl%0d_credits", i), int'(credits), tbl[i].e_cr);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].e_err));
      @(posedge clk);
      #1;
    end

    // Sticky error clears only through reset.
    do_reset();
    @(negedge clk);
    chk("post_reset_err", int'(err), 0);
    chk("post_reset_credits", int'(credits), DEPTH);
    chk("post_reset_count", int'(count), 0);
    @(posedge clk);
    #1;

    // Bypass corner: one launch returning 0xA5 into an empty FIFO with the consumer ready.
    step(1'b1, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("byp_same_cycle_valid", int'(last_ov), int'(BYP));
    if (BYP) chk("byp_same_cycle_data", int'(last_od), 8'hA5);
    chk("byp_count_after", int'(count), BYP ? 0 : 1);
    bus.ret_valid = 1'b0;
    #1;
    chk("byp_next_cycle_valid", int'(bus.out_valid), BYP ? 0 : 1);
    if (!BYP) chk("byp_next_cycle_data", int'(bus.out_data), 8'hA5);
    repeat (3) step(1'b0, 1'b1, 8'h00);

    // Continuous launching against an always-ready consumer. The credit loop is
    // launch -> arrival -> pop -> credit, which is one cycle shorter with bypass;
    // without it a 4-deep catcher at LATENCY=3 sustains 4 results every 5 cycles.
    do_reset();
    delivered = 0;
    drops     = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_cr == 0) drops++;
      step(1'b1 && (m_cr != 0), 1'b1, 8'($urandom));
      if (last_ov) delivered++;
    end
    thr = BYP ? 36 : 25;
    chk("cont_throughput_ok", int'(delivered >= thr), 1);
    if (BYP) chk("cont_ready_drops", drops, 0);
    chk("cont_err", int'(err), 0);

    // Random traffic, well-behaved launcher.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step((m_cr != 0) && ($urandom_range(0, 3) != 0), $urandom_range(0, 9) < 6, 8'($urandom));
    end
    chk("rand_legal_err", int'(err), 0);

    // Random traffic including launches without credit.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
